// File: rtl/parallel_mem_read_streamer.sv
// Read-side sequencer for a bank of z simple dual-port memories with a registered read port B.
// A start command sweeps a contiguous, wrapping address range. Each cycle the same address goes
// to all z lanes, and the returned z-wide words leave as a valid/ready stream through a 4-entry
// FIFO. Issue is throttled so that words already in the FIFO plus reads still in flight never
// exceed the FIFO capacity. A downstream stall therefore cannot drop or repeat a read.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   start               command strobe, accepted only while idle
//   base_addr, count    first address and number of words, sampled with start
//   busy, done          command in progress / one-cycle completion pulse
//   mem_addressB        registered read address, one per lane (all lanes equal)
//   mem_data_outB       lane read data, valid the cycle after the address edge
//   out_data, out_valid, out_ready   output stream (payload is the FIFO head)
module parallel_mem_read_streamer #(
  parameter int unsigned z     = 2,
  parameter int unsigned depth = 16,
  parameter int unsigned width = 12,
  localparam int unsigned addrsize = (depth == 1) ? 1 : $clog2(depth)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [addrsize-1:0] base_addr,
  input  logic [addrsize:0]   count,
  output logic                busy,
  output logic                done,
  output logic [addrsize-1:0] mem_addressB [z],
  input  logic [width-1:0]    mem_data_outB [z],
  output logic [width-1:0]    out_data [z],
  output logic                out_valid,
  input  logic                out_ready
);

  localparam logic [addrsize-1:0] AddrOne  = 1;
  localparam logic [addrsize-1:0] AddrLast = addrsize'(depth - 1);
  localparam logic [addrsize:0]   CntOne   = 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e              state_q, state_d;
  logic [addrsize-1:0] addr_q, addr_d;             // next address to issue
  logic [addrsize-1:0] issue_addr_q, issue_addr_d; // drives mem_addressB
  logic [addrsize:0]   remain_q, remain_d;         // reads still to issue
  logic                done_q, done_d;

  // iss1_q: address registered this cycle; iss2_q: its data is on mem_data_outB now.
  logic                iss1_q, iss2_q;
  logic                issue;

  logic [width-1:0]    fifo_mem_q [4][z];
  logic [1:0]          wr_ptr_q, rd_ptr_q;
  logic [2:0]          fifo_cnt_q;
  logic                push, pop;
  logic [3:0]          occ;
  logic                issue_ok;

  assign push      = iss2_q;
  assign out_valid = (fifo_cnt_q != 3'd0);
  assign pop       = out_valid & out_ready;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;

  // Slots committed after this edge, excluding a new issue. A pop frees a slot this same edge.
  assign occ      = {1'b0, fifo_cnt_q} + {3'b0, iss1_q} + {3'b0, iss2_q} - {3'b0, pop};
  assign issue_ok = (occ < 4'd4);

  always_comb begin
    for (int j = 0; j < int'(z); j++) begin
      mem_addressB[j] = issue_addr_q;
      out_data[j]     = fifo_mem_q[rd_ptr_q][j];
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    issue_addr_d = issue_addr_q;
    remain_d     = remain_q;
    done_d       = 1'b0;
    issue        = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (count != '0) begin
            addr_d   = base_addr;
            remain_d = count;
            state_d  = StRun;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (issue_ok) begin
          issue        = 1'b1;
          issue_addr_d = addr_q;
          addr_d       = (addr_q == AddrLast) ? '0 : addr_q + AddrOne;
          remain_d     = remain_q - CntOne;
          if (remain_q == CntOne) state_d = StDrain;
        end
      end
      StDrain: begin
        // Finish on the edge that empties the FIFO with nothing left in flight.
        if (!iss1_q && !iss2_q &&
            ((fifo_cnt_q == 3'd0) || ((fifo_cnt_q == 3'd1) && pop))) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      issue_addr_q <= '0;
      remain_q     <= '0;
      done_q       <= 1'b0;
      iss1_q       <= 1'b0;
      iss2_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_addr_q <= issue_addr_d;
      remain_q     <= remain_d;
      done_q       <= done_d;
      iss1_q       <= issue;
      iss2_q       <= iss1_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < int'(z); j++) begin
          fifo_mem_q[i][j] <= '0;
        end
      end
    end else begin
      if (push) begin
        for (int j = 0; j < int'(z); j++) begin
          fifo_mem_q[wr_ptr_q][j] <= mem_data_outB[j];
        end
        wr_ptr_q <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 3'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 3'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_parallel_mem_read_streamer.sv
// Directed bench: a behavioural port-B memory (lane j, cell a holds a*16+j) feeds the streamer.
// A negedge monitor logs handshakes, done pulses, address changes and stall stability.
module tb_parallel_mem_read_streamer;

  localparam int Z  = 2;
  localparam int D  = 16;
  localparam int W  = 12;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   count = '0;
  logic          busy, done, out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] mem_addressB [Z];
  logic [W-1:0]  mem_data_outB [Z];
  logic [W-1:0]  out_data [Z];

  logic [W-1:0]  mem [Z][D];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int rdy_mode = 0;

  logic [23:0]   rx_q[$];
  int            rx_cyc[$];
  logic [AW-1:0] addr_log[$];
  int            done_cnt = 0, done_cyc = -1, last_hs_cyc = -1, rise_cyc = -1, valid_cnt = 0;
  logic          prev_stall = 1'b0, valid_prev = 1'b0;
  logic [23:0]   stall_word = '0;
  logic [AW-1:0] prev_addr = '0;

  parallel_mem_read_streamer #(.z(Z), .depth(D), .width(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .count        (count),
    .busy         (busy),
    .done         (done),
    .mem_addressB (mem_addressB),
    .mem_data_outB(mem_data_outB),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered read port B.
  always @(posedge clk) begin
    for (int j = 0; j < Z; j++) mem_data_outB[j] <= mem[j][mem_addressB[j]];
  end

  always @(posedge clk) begin
    #1;
    out_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] exp_word(input int a);
    logic [11:0] l0;
    l0 = 12'((a % D) * 16);
    return {l0 + 12'd1, l0};
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
      valid_prev = 1'b0;
      prev_addr  = '0;
    end else begin
      if (prev_stall)
        check("stall_hold", {7'b0, out_valid, out_data[1], out_data[0]}, {8'h01, stall_word});
      if (out_valid && out_ready) begin
        rx_q.push_back({out_data[1], out_data[0]});
        rx_cyc.push_back(cyc);
        last_hs_cyc = cyc;
      end
      if (out_valid && !valid_prev) rise_cyc = cyc;
      if (out_valid) valid_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (mem_addressB[0] != prev_addr) addr_log.push_back(mem_addressB[0]);
      prev_addr  = mem_addressB[0];
      prev_stall = out_valid && !out_ready;
      stall_word = {out_data[1], out_data[0]};
      valid_prev = out_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns the cycle number of the edge that samples start.
  task automatic send(input int b, input int c, output int s_edge);
    base_addr = AW'(b);
    count     = (AW + 1)'(c);
    start     = 1'b1;
    s_edge    = cyc + 1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int limit, input string tag);
    int n = 0;
    while (done_cnt == d0 && n < limit) begin
      step();
      n++;
    end
    check(tag, 32'(done_cnt != d0), 32'd1);
  endtask

  task automatic clear_logs();
    rx_q.delete();
    rx_cyc.delete();
    addr_log.delete();
  endtask

  task automatic check_words(input string tag, input int b, input int c);
    check({tag, "_n"}, 32'(rx_q.size()), 32'(c));
    for (int i = 0; i < c && i < rx_q.size(); i++)
      check(tag, 32'(rx_q[i]), 32'(exp_word(b + i)));
  endtask

  initial begin
    int s_edge, s2, d0, a0, v0, n;

    for (int j = 0; j < Z; j++)
      for (int a = 0; a < D; a++) mem[j][a] = 12'(a * 16 + j);

    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_addr", {24'b0, mem_addressB[1], mem_addressB[0]}, 32'd0);
    check("rst_data", {8'b0, out_data[1], out_data[0]}, 32'd0);
    step();
    reset = 1'b1;
    step();

    // base=0, count=4, ready high
    clear_logs();
    d0 = done_cnt;
    send(0, 4, s_edge);
    wait_done(d0, 60, "t1_done");
    check_words("t1_word", 0, 4);
    check("t1_latency", 32'(rise_cyc - s_edge), 32'd3);
    if (rx_cyc.size() == 4) check("t1_back2back", 32'(rx_cyc[3] - rx_cyc[0]), 32'd3);
    check("t1_done_when", 32'(done_cyc), 32'(last_hs_cyc + 1));
    check("t1_busy", 32'(busy), 32'd0);
    repeat (3) step();
    check("t1_done_once", 32'(done_cnt - d0), 32'd1);

    // wrap: base=14, count=5
    clear_logs();
    d0 = done_cnt;
    send(14, 5, s_edge);
    wait_done(d0, 60, "t2_done");
    check("t2_addr_n", 32'(addr_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < addr_log.size(); i++)
      check("t2_addr", 32'(addr_log[i]), 32'((14 + i) % D));
    check_words("t2_word", 14, 5);

    // backpressure 1,0,0 pattern, count=8
    clear_logs();
    rdy_mode = 1;
    d0 = done_cnt;
    send(3, 8, s_edge);
    wait_done(d0, 120, "t3_done");
    check_words("t3_word", 3, 8);
    check("t3_done_when", 32'(done_cyc), 32'(last_hs_cyc + 1));
    rdy_mode = 0;
    step();

    // count=0
    clear_logs();
    d0 = done_cnt;
    a0 = addr_log.size();
    v0 = valid_cnt;
    send(7, 0, s_edge);
    repeat (3) step();
    check("t4_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("t4_done_when", 32'(done_cyc), 32'(s_edge));
    check("t4_no_issue", 32'(addr_log.size()), 32'(a0));
    check("t4_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);

    // start while busy is ignored
    clear_logs();
    d0 = done_cnt;
    send(2, 4, s_edge);
    step();
    send(10, 1, s2);
    wait_done(d0, 60, "t4b_done");
    repeat (4) step();
    check("t4b_done_once", 32'(done_cnt - d0), 32'd1);
    check_words("t4b_word", 2, 4);

    // reset mid-sweep after 3 handshakes
    clear_logs();
    d0 = done_cnt;
    send(0, 8, s_edge);
    n = 0;
    while (rx_q.size() < 3 && n < 40) begin
      step();
      n++;
    end
    check("t5_three_hs", 32'(rx_q.size()), 32'd3);
    reset = 1'b0;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_addr", {24'b0, mem_addressB[1], mem_addressB[0]}, 32'd0);
    step();
    step();
    reset = 1'b1;
    clear_logs();
    v0 = valid_cnt;
    repeat (5) step();
    check("t5_no_stale", 32'(valid_cnt - v0), 32'd0);
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);
    send(5, 2, s_edge);
    wait_done(d0, 60, "t5_done");
    check_words("t5_word", 5, 2);

    // full sweep count=depth from base=9
    clear_logs();
    d0 = done_cnt;
    send(9, 16, s_edge);
    wait_done(d0, 80, "t6_done");
    check_words("t6_word", 9, 16);
    check("t6_done_when", 32'(done_cyc), 32'(last_hs_cyc + 1));
    repeat (3) step();
    check("t6_done_once", 32'(done_cnt - d0), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
